// File: rtl/ifetch_bus.sv
// Instruction fetch bus adapter: issues one single-beat instruction-bus request at a time
// and delivers the returned word with its address, squashing responses made stale by redirect.
module ifetch_bus #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pc,
  input  logic        redirect,
  input  logic        hold,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  output logic        instr_valid,
  output logic        stallI
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [63:0] addr_reg;
  logic [31:0] instr_reg;
  logic [63:0] instr_pc_reg;

  logic        launch;
  logic        capture;

  // A request is launched only from IDLE; the response is kept only if no redirect
  // arrived while it was in flight (DROP) or in the same cycle.
  assign launch  = (state_reg == IDLE) && !redirect;
  assign capture = (state_reg == REQ) && iresp_data_ok && !redirect;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (!redirect) state_next = REQ;
      end
      REQ: begin
        if (iresp_data_ok) begin
          state_next = redirect ? IDLE : DONE;
        end else if (redirect) begin
          state_next = DROP;
        end
      end
      DROP: begin
        if (iresp_data_ok) state_next = IDLE;
      end
      DONE: begin
        if (redirect || !hold) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ireq_valid  = 1'b0;
    instr_valid = 1'b0;
    stallI      = 1'b1;
    case (state_reg)
      REQ, DROP: ireq_valid = 1'b1;
      DONE: begin
        instr_valid = 1'b1;
        stallI      = 1'b0;
      end
      default: ;
    endcase
  end

  // Address is frozen from launch until the response, so the bus sees a stable request.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg     <= 64'h0;
      instr_reg    <= 32'h0;
      instr_pc_reg <= RESET_PC;
    end else begin
      if (launch) addr_reg <= pc;
      if (capture) begin
        instr_reg    <= iresp_data;
        instr_pc_reg <= addr_reg;
      end
    end
  end

  assign ireq_addr = addr_reg;
  assign instr     = instr_reg;
  assign instr_pc  = instr_pc_reg;

endmodule

// File: tb/tb_ifetch_bus.sv
// Bench for ifetch_bus: directed scenarios then random traffic, every cycle compared
// against a transaction-level model of the fetch unit.
module tb_ifetch_bus;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc;
  logic        redirect;
  logic        hold;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_valid;
  logic        stallI;

  int checks = 0;
  int fails  = 0;

  // Model: a request is either absent, live, or poisoned by a redirect;
  // a fetched instruction is either held for the consumer or not.
  logic        m_busy;
  logic        m_poisoned;
  logic        m_have;
  logic [63:0] m_addr;
  logic [31:0] m_instr;
  logic [63:0] m_pc;

  ifetch_bus #(.RESET_PC(RST_PC)) dut (
    .clk(clk),
    .reset(reset),
    .pc(pc),
    .redirect(redirect),
    .hold(hold),
    .ireq_valid(ireq_valid),
    .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok),
    .iresp_data(iresp_data),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_valid(instr_valid),
    .stallI(stallI)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("ireq_valid", {63'h0, ireq_valid}, {63'h0, m_busy});
    check("ireq_addr", ireq_addr, m_addr);
    check("instr_valid", {63'h0, instr_valid}, {63'h0, m_have});
    check("stallI", {63'h0, stallI}, {63'h0, !m_have});
    check("instr", {32'h0, instr}, {32'h0, m_instr});
    check("instr_pc", instr_pc, m_pc);
  endtask

  task automatic model_step(input logic r, input logic rd, input logic h, input logic ok,
                            input logic [31:0] d, input logic [63:0] p);
    if (r) begin
      m_busy = 0; m_poisoned = 0; m_have = 0;
      m_addr = 64'h0; m_instr = 32'h0; m_pc = RST_PC;
    end else if (m_have) begin
      if (rd || !h) m_have = 0;
    end else if (m_busy) begin
      if (ok) begin
        if (!m_poisoned && !rd) begin
          m_have  = 1;
          m_instr = d;
          m_pc    = m_addr;
        end
        m_busy     = 0;
        m_poisoned = 0;
      end else if (rd) begin
        m_poisoned = 1;
      end
    end else if (!rd) begin
      m_busy = 1;
      m_addr = p;
    end
  endtask

  task automatic cycle(input logic r, input logic rd, input logic h, input logic ok,
                       input logic [31:0] d, input logic [63:0] p);
    reset = r; redirect = rd; hold = h; iresp_data_ok = ok; iresp_data = d; pc = p;
    @(posedge clk);
    model_step(r, rd, h, ok, d, p);
    #1;
    check_all();
  endtask

  logic [63:0] cur_pc;
  logic        r_rst, r_rd, r_h, r_ok;

  initial begin
    m_busy = 0; m_poisoned = 0; m_have = 0;
    m_addr = 0; m_instr = 0; m_pc = RST_PC;

    // Reset state
    cycle(1, 0, 0, 0, 32'h0, RST_PC);
    cycle(1, 0, 0, 0, 32'h0, RST_PC);
    check("rst_stallI", {63'h0, stallI}, 64'h1);

    // Basic fetch with three wait cycles
    cycle(0, 0, 0, 0, 32'h0, RST_PC);
    check("basic_addr", ireq_addr, 64'h8000_0000);
    cycle(0, 0, 0, 0, 32'h0, RST_PC);
    cycle(0, 0, 0, 0, 32'h0, RST_PC);
    cycle(0, 0, 0, 1, 32'h0000_0013, RST_PC);
    check("basic_instr", {32'h0, instr}, 64'h13);
    check("basic_valid", {63'h0, instr_valid}, 64'h1);
    cycle(0, 0, 0, 0, 32'h0, RST_PC + 4);
    check("basic_stall_back", {63'h0, stallI}, 64'h1);

    // Zero-wait stream from a fresh reset, pc advancing on each consumption
    cycle(1, 0, 0, 0, 32'h0, RST_PC);
    cur_pc = RST_PC;
    for (int i = 0; i < 9; i++) begin
      logic consume;
      consume = m_have;
      cycle(0, 0, 0, 1, 32'h1000_0000 + 32'(i), cur_pc);
      if (consume) cur_pc = cur_pc + 4;
      if (i % 3 == 1) check("stream_pc", instr_pc, RST_PC + 64'(4 * (i / 3)));
    end

    // Redirect while waiting, second redirect inside DROP, then new address
    cycle(0, 0, 0, 0, 32'h0, RST_PC);
    cycle(0, 1, 0, 0, 32'h0, RST_PC);
    cycle(0, 1, 0, 0, 32'h0, 64'h8000_1000);
    check("drop_addr", ireq_addr, RST_PC);
    cycle(0, 0, 0, 1, 32'hdead_beef, 64'h8000_1000);
    check("drop_no_valid", {63'h0, instr_valid}, 64'h0);
    cycle(0, 0, 0, 0, 32'h0, 64'h8000_1000);
    check("redir_addr", ireq_addr, 64'h8000_1000);
    cycle(0, 0, 0, 1, 32'h0000_1111, 64'h8000_1000);
    cycle(0, 0, 0, 0, 32'h0, 64'h8000_1004);

    // Redirect coinciding with data_ok
    cycle(0, 0, 0, 0, 32'h0, 64'h8000_2000);
    cycle(0, 1, 0, 1, 32'hbad0_bad0, 64'h8000_2000);
    check("same_cyc_instr", {32'h0, instr}, 64'h1111);
    cycle(0, 0, 0, 0, 32'h0, 64'h8000_3000);
    check("same_cyc_req", {63'h0, ireq_valid}, 64'h1);

    // Hold in DONE for four cycles
    cycle(0, 0, 1, 1, 32'h0000_2222, 64'h8000_3000);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 32'h0, 64'h8000_3000);
    check("hold_pc", instr_pc, 64'h8000_3000);
    cycle(0, 0, 0, 0, 32'h0, 64'h8000_3004);
    cycle(0, 0, 0, 0, 32'h0, 64'h8000_3004);

    // Reset in the middle of DROP
    cycle(0, 1, 0, 0, 32'h0, 64'h8000_3004);
    cycle(1, 0, 0, 0, 32'h0, 64'h8000_3004);
    check("rst_drop_pc", instr_pc, RST_PC);
    check("rst_drop_req", {63'h0, ireq_valid}, 64'h0);

    // Random traffic, including responses arriving outside a request
    for (int i = 0; i < 600; i++) begin
      r_rst = ($urandom_range(0, 63) == 0);
      r_rd  = ($urandom_range(0, 4) == 0);
      r_h   = $urandom_range(0, 1) == 1;
      r_ok  = ($urandom_range(0, 2) == 0);
      cycle(r_rst, r_rd, r_h, r_ok, $urandom, {$urandom, $urandom_range(0, 255) * 4});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ifetch_bus.md
IFETCH_BUS -- requirements
Module: ifetch_bus

Interface
REQ-001 Parameter RESET_PC, default 64'h8000_0000, SHALL be the reset value of instr_pc.
REQ-002 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 pc  input  64  current fetch address from the PC register.
REQ-005 redirect  input  1  jump/flush this cycle; the value on pc is stale.
REQ-006 hold  input  1  downstream stall; the delivered instruction is not consumed.
REQ-007 ireq_valid  output  1  instruction-bus request valid.
REQ-008 ireq_addr  output  64  instruction-bus request address.
REQ-009 iresp_data_ok  input  1  single-beat response; iresp_data is valid this cycle.
REQ-010 iresp_data  input  32  instruction word.
REQ-011 instr  output  32  delivered instruction (registered).
REQ-012 instr_pc  output  64  address of instr (registered).
REQ-013 instr_valid  output  1  instr/instr_pc are valid for consumption.
REQ-014 stallI  output  1  fetch not complete; PC register SHALL hold.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, REQ, DROP and DONE.
REQ-016 IDLE: if !redirect, the block SHALL latch pc into the address register and go to REQ; if redirect, it SHALL stay in IDLE.
REQ-017 ireq_valid SHALL be 1 exactly in REQ and DROP, and ireq_addr SHALL equal the latched address.
REQ-018 Once ireq_valid is raised, ireq_valid and ireq_addr SHALL stay stable until the cycle iresp_data_ok=1, including across redirect.
REQ-019 REQ, data_ok=1, redirect=0: the block SHALL capture iresp_data into instr and the address into instr_pc, then go to DONE.
REQ-020 REQ, data_ok=1, redirect=1: the block SHALL discard the data, go to IDLE, and leave instr and instr_pc unchanged.
REQ-021 REQ, data_ok=0, redirect=1: the block SHALL go to DROP.
REQ-022 REQ, data_ok=0, redirect=0: the block SHALL stay in REQ.
REQ-023 DROP: on data_ok=1 the block SHALL discard the data and go to IDLE; otherwise it SHALL stay in DROP, and a further redirect SHALL have no additional effect.
REQ-024 DONE: instr_valid SHALL be 1, and instr and instr_pc SHALL stay stable.
REQ-025 DONE: if redirect=1, the block SHALL go to IDLE and the instruction is dropped.
REQ-026 DONE: else if hold=0, the instruction is consumed and the block SHALL go to IDLE.
REQ-027 DONE: else (hold=1) the block SHALL stay in DONE.
REQ-028 instr_valid SHALL be 0 in IDLE, REQ and DROP.
REQ-029 stallI SHALL be 0 only in DONE, and 1 in all other states.
REQ-030 Latency: zero-wait memory SHALL give instr_valid 2 cycles after IDLE is entered, with a throughput of one instruction per 3 cycles; each wait cycle adds one cycle.
REQ-031 At most one bus request SHALL be outstanding at any time.
REQ-032 Data arriving while not in REQ or DROP SHALL be ignored.

Reset
REQ-033 On reset the block SHALL enter state IDLE.
REQ-034 On reset ireq_valid SHALL be 0, instr_valid SHALL be 0, and stallI SHALL be 1.
REQ-035 On reset instr SHALL be 32'h0, instr_pc SHALL be RESET_PC, and the address register SHALL be 64'h0.
REQ-036 Reset in any state, including REQ or DROP with a request outstanding, SHALL abandon the request, with ireq_valid 0 on the following cycle.
REQ-037 The memory side is reset by the same reset signal.

Verification
REQ-038 Basic fetch: release reset with pc=0x8000_0000 and data_ok 3 cycles after ireq_valid rises, data 0x00000013 -> ireq_addr=0x8000_0000 and held stable; next cycle instr_valid=1, instr=0x13, instr_pc=0x8000_0000, stallI=0 for that cycle only.
REQ-039 Zero-wait stream: data_ok tied 1, pc steps +4 on each consumed instruction -> instr_valid every 3rd cycle, instr_pc 0x8000_0000, 0x8000_0004, 0x8000_0008.
REQ-040 Redirect while waiting: redirect in cycle 1 of REQ, data_ok 2 cycles later -> DROP; addr unchanged until data_ok; no instr_valid; next request addr = new pc (e.g. 0x8000_1000).
REQ-041 Redirect with data_ok in the same cycle -> data discarded, instr still holds its previous value, IDLE next cycle, new request the following cycle.
REQ-042 Hold: in DONE with hold=1 for 4 cycles -> instr/instr_pc stable, instr_valid=1, ireq_valid=0; hold drops -> IDLE, then new request.
REQ-043 Reset mid-DROP -> next cycle ireq_valid=0, instr_valid=0, instr_pc=0x8000_0000, state IDLE.
